mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit directly downstream of the instruction fetch unit.
- Consumes the fetched 32-bit instruction and the ALU zero flag.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives the datapath strobes, plus the PC-advance enable and the branch/jump selects consumed by the fetch unit.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.
- RESET_STATE, 3'd0, encoding loaded into the state register on reset (FETCH).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low: state cleared on a rising clk edge while rst==0.
- inst  in  32  current instruction from fetch unit; stable while pc_en==0.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- pc_en  out  1  one-cycle pulse; fetch unit updates PC only when high.
- ct_branch  out  1  branch select to fetch unit; meaningful only with pc_en.
- ct_jump  out  1  jump select to fetch unit; meaningful only with pc_en.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  1  1=rd, 0=rt destination.
- alu_src  out  1  1=sign-extended immediate, 0=rt.
- mem_read  out  1  data-memory read strobe.
- mem_write  out  1  data-memory write strobe.
- mem_to_reg  out  1  1=write-back from memory, 0=from ALU.
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt.
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP.
- illegal  out  1  unsupported opcode/funct seen.
- retire_cnt  out  RETIRE_W  count of pc_en pulses since reset.

Behaviour:
- Reset (rst==0 at clk edge):
  - state=FETCH, IR=0, retire_cnt=0, illegal=0.
  - All strobes are 0 in FETCH.
  - Reset mid-instruction aborts it; no pc_en is emitted.
- Instruction register:
  - IR captures inst on the FETCH->DECODE edge.
  - All decode uses IR, never live inst.
- Supported opcodes:
  - R-type (op 0x00, funct add 0x20/sub 0x22/and 0x24/or 0x25/slt 0x2A).
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- Transitions:
  - FETCH->DECODE always.
  - DECODE->EXEC always.
  - EXEC->MEM for lw/sw.
  - EXEC->WB for R-type/addi.
  - EXEC->FETCH for beq/j.
  - MEM->WB for lw.
  - MEM->FETCH for sw.
  - WB->FETCH always.
- Latencies (cycles per instruction):
  - beq, j: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
- Outputs are Moore-style from state plus IR, combinational, glitch-free relative to clk.
- EXEC:
  - alu_op from funct (R-type), add (addi/lw/sw), sub (beq).
  - alu_src=1 for addi/lw/sw.
- MEM: mem_read=1 for lw; mem_write=1 for sw.
- WB:
  - reg_write=1.
  - reg_dst=1 only for R-type.
  - mem_to_reg=1 only for lw.
- pc_en:
  - High for exactly one cycle, in the final state of each instruction (EXEC for beq/j, MEM for sw, WB otherwise).
  - ct_branch=1 in that cycle for beq regardless of alu_zero; fetch unit gates on alu_zero.
  - ct_jump=1 in that cycle for j.
  - ct_branch and ct_jump are never both 1.
- retire_cnt increments on every clk edge where pc_en==1 and wraps modulo 2^RETIRE_W.
- illegal is a registered flag:
  - Set in DECODE on an unsupported opcode, or on an unsupported funct with op 0.
  - Cleared only by reset.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal instruction goes DECODE->TRAP.
  - TRAP holds forever (pc_en=0, all strobes 0, state=7) until reset.
  - illegal=1.
- Undefined:
  - Illegal instruction is executed as NOP: DECODE->EXEC, pc_en pulse in EXEC, no strobes.
  - illegal still sets.
  - TRAP state is unreachable.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> state=0, pc_en=0, retire_cnt=0, all strobes 0.
- inst=0x00221820 (add $3,$1,$2):
  - state 0,1,2,4.
  - alu_op=0 in EXEC.
  - reg_write=1 and reg_dst=1 in WB, with pc_en=1 in that same cycle.
  - retire_cnt=1.
- inst=0x8C080004 (lw $8,4($0)):
  - 5 cycles.
  - mem_read=1 in MEM.
  - mem_to_reg=1 and reg_write=1 in WB.
  - pc_en only in WB.
- inst=0x10000002 (beq), alu_zero=1:
  - pc_en=1 and ct_branch=1 in EXEC (cycle 3).
  - ct_jump=0, alu_op=1.
  - Repeat with inst=0x08000040 (j) -> ct_jump=1, ct_branch=0 in EXEC.
- inst=0xFC000000 (op 0x3F):
  - With MC_CTRL_ILLEGAL_TRAP_EN: illegal=1, state=7 held 10+ cycles, pc_en=0.
  - Without: illegal=1, pc_en pulse in cycle 3, no strobes.
- Mid-instruction reset: assert rst=0 during lw MEM state -> next state=0, no pc_en, retire_cnt=0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath strobes. Optional macro MC_CTRL_ILLEGAL_TRAP_EN parks illegal ops in TRAP.
module mc_ctrl_fsm #(
  parameter int unsigned RETIRE_W    = 32,
  parameter logic [2:0]  RESET_STATE = 3'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst,
  input  logic                alu_zero,
  output logic                pc_en,
  output logic                ct_branch,
  output logic                ct_jump,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [2:0]          alu_op,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [INST_W-1:0]     r_ir;
  logic                  r_illegal;
  logic [RETIRE_W-1:0]   r_retire_cnt;

  logic [OP_W-1:0]       w_op;
  logic [OP_W-1:0]       w_funct;
  logic                  w_is_r;
  logic                  w_is_addi;
  logic                  w_is_lw;
  logic                  w_is_sw;
  logic                  w_is_beq;
  logic                  w_is_j;
  logic                  w_legal;
  logic [ALU_OP_W-1:0]   w_r_alu_op;

  logic                  w_pc_en;
  logic                  w_ct_branch;
  logic                  w_ct_jump;
  logic                  w_reg_write;
  logic                  w_reg_dst;
  logic                  w_alu_src;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_mem_to_reg;
  logic [ALU_OP_W-1:0]   w_alu_op;
  logic                  w_unused_bits;

  // Instruction class decode, always from the captured IR
  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_j    = (w_op == OP_J);
  assign w_legal   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_j;

  always_comb begin
    w_is_r     = 1'b0;
    w_r_alu_op = ALU_ADD;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        6'h20: begin w_is_r = 1'b1; w_r_alu_op = ALU_ADD; end
        6'h22: begin w_is_r = 1'b1; w_r_alu_op = ALU_SUB; end
        6'h24: begin w_is_r = 1'b1; w_r_alu_op = ALU_AND; end
        6'h25: begin w_is_r = 1'b1; w_r_alu_op = ALU_OR;  end
        6'h2A: begin w_is_r = 1'b1; w_r_alu_op = ALU_SLT; end
        default: ;
      endcase
    end
  end

  // State register, IR capture, sticky illegal flag and retire counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= state_t'(RESET_STATE);
      r_ir         <= '0;
      r_illegal    <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_ir <= inst;
      end
      if ((r_state == S_DECODE) && !w_legal) begin
        r_illegal <= 1'b1;
      end
      if (pc_en) begin
        r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
      end
    end
  end

  // Next state and Moore outputs from state plus IR
  always_comb begin
    w_next       = S_FETCH;
    w_pc_en      = 1'b0;
    w_ct_branch  = 1'b0;
    w_ct_jump    = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_op     = ALU_ADD;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        w_next = w_legal ? S_EXEC : S_TRAP;
`else
        w_next = S_EXEC;
`endif
      end
      S_EXEC: begin
        w_alu_src = w_is_addi | w_is_lw | w_is_sw;
        if (w_is_r) begin
          w_alu_op = w_r_alu_op;
        end else if (w_is_beq) begin
          w_alu_op = ALU_SUB;
        end
        if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else if (w_is_r || w_is_addi) begin
          w_next = S_WB;
        end else begin
          // beq, j and illegal-as-NOP retire here
          w_next      = S_FETCH;
          w_pc_en     = 1'b1;
          w_ct_branch = w_is_beq;
          w_ct_jump   = w_is_j;
        end
      end
      S_MEM: begin
        w_mem_read  = w_is_lw;
        w_mem_write = w_is_sw;
        w_next      = w_is_lw ? S_WB : S_FETCH;
        w_pc_en     = !w_is_lw;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = w_is_r;
        w_mem_to_reg = w_is_lw;
        w_pc_en      = 1'b1;
        w_next       = S_FETCH;
      end
      S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        w_next = S_TRAP;
`else
        w_next = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  // A reset asserted mid-instruction suppresses the retire pulse
  assign pc_en      = w_pc_en & rst;
  assign ct_branch  = w_ct_branch & rst;
  assign ct_jump    = w_ct_jump & rst;
  assign reg_write  = w_reg_write;
  assign reg_dst    = w_reg_dst;
  assign alu_src    = w_alu_src;
  assign mem_read   = w_mem_read;
  assign mem_write  = w_mem_write;
  assign mem_to_reg = w_mem_to_reg;
  assign alu_op     = w_alu_op;
  assign state      = r_state;
  assign illegal    = r_illegal;
  assign retire_cnt = r_retire_cnt;

  // Branch resolution happens in the fetch unit; operand fields are datapath-only
  assign w_unused_bits = ^{r_ir[25:6], alu_zero};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: an instruction-level model pushes per-cycle expectations,
// a negedge monitor pops and compares. Honours MC_CTRL_ILLEGAL_TRAP_EN like the design.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_en;
    logic       br;
    logic       jp;
    logic       rw;
    logic       rd;
    logic       as;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic [2:0] op;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic [31:0] ret;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = '0;
  logic        alu_zero = 1'b0;
  logic        pc_en, ct_branch, ct_jump, reg_write, reg_dst, alu_src;
  logic        mem_read, mem_write, mem_to_reg, illegal;
  logic [2:0]  alu_op, state;
  logic [31:0] retire_cnt;

  exp_t        exp_q[$];
  bit          mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_ret = '0;
  logic        m_ill = 1'b0;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .inst(inst), .alu_zero(alu_zero),
    .pc_en(pc_en), .ct_branch(ct_branch), .ct_jump(ct_jump),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .state(state), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t dut_vec();
    return {state, pc_en, ct_branch, ct_jump, reg_write, reg_dst, alu_src,
            mem_read, mem_write, mem_to_reg, alu_op};
  endfunction

  // Reference model: instruction class -> list of per-cycle expected outputs
  task automatic push_model(input logic [31:0] i, output int len);
    logic [5:0] op, fn;
    logic [2:0] rop;
    bit is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal;
    exp_t e;
    op = i[31:26];
    fn = i[5:0];
    is_r = 1'b0;
    rop = 3'd0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin is_r = 1'b1; rop = 3'd0; end
        6'h22: begin is_r = 1'b1; rop = 3'd1; end
        6'h24: begin is_r = 1'b1; rop = 3'd2; end
        6'h25: begin is_r = 1'b1; rop = 3'd3; end
        6'h2A: begin is_r = 1'b1; rop = 3'd4; end
        default: ;
      endcase
    end
    is_addi = (op == 6'h08);
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_beq  = (op == 6'h04);
    is_j    = (op == 6'h02);
    legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_j;
    e = '0;
    e.ret = m_ret;
    e.ill = m_ill;
    e.v.st = 3'd0; exp_q.push_back(e);
    e.v.st = 3'd1; exp_q.push_back(e);
    if (!legal) m_ill = 1'b1;
    e.ill = m_ill;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (!legal) begin
      e.v = '0;
      e.v.st = 3'd7;
      for (int k = 0; k < 12; k++) exp_q.push_back(e);
      len = 14;
      return;
    end
`endif
    e.v = '0;
    e.v.st = 3'd2;
    e.v.op = is_r ? rop : (is_beq ? 3'd1 : 3'd0);
    e.v.as = is_addi | is_lw | is_sw;
    e.v.pc_en = !(is_r | is_addi | is_lw | is_sw);
    e.v.br = is_beq;
    e.v.jp = is_j;
    exp_q.push_back(e);
    len = 3;
    if (is_lw || is_sw) begin
      e.v = '0;
      e.v.st = 3'd3;
      e.v.mr = is_lw;
      e.v.mw = is_sw;
      e.v.pc_en = is_sw;
      exp_q.push_back(e);
      len++;
    end
    if (is_r || is_addi || is_lw) begin
      e.v = '0;
      e.v.st = 3'd4;
      e.v.rw = 1'b1;
      e.v.rd = is_r;
      e.v.m2r = is_lw;
      e.v.pc_en = 1'b1;
      exp_q.push_back(e);
      len++;
    end
    m_ret++;
  endtask

  // Issue one instruction in FETCH and wait until the FSM is back in FETCH
  task automatic issue(input logic [31:0] i);
    int len;
    inst = i;
    push_model(i, len);
    mon_en = 1'b1;
    for (int c = 0; c < len; c++) begin
      alu_zero = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Reset for two edges, check reset state, then start instruction i
  task automatic reset_and_load(input logic [31:0] i, output int len);
    rst = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_ret = '0;
    m_ill = 1'b0;
    @(posedge clk);
    #1;
    check("reset_vec", 64'(dut_vec()), 64'd0);
    check("reset_retire", 64'(retire_cnt), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);
    inst = i;
    push_model(i, len);
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cycle_vec", 64'(dut_vec()), 64'(e.v));
        check("retire_cnt", 64'(retire_cnt), 64'(e.ret));
        check("illegal", 64'(illegal), 64'(e.ill));
        check("ct_exclusive", 64'(ct_branch & ct_jump), 64'd0);
      end
    end
  end

  function automatic logic [31:0] rand_inst(input bit allow_illegal);
    logic [31:0] r;
    logic [5:0]  fns [5];
    logic [5:0]  bad [4];
    int          k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bad = '{6'h3F, 6'h01, 6'h0F, 6'h2F};
    r = $urandom;
    k = allow_illegal ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 5));
    case (k)
      0: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 4)]; end
      1: r[31:26] = 6'h08;
      2: r[31:26] = 6'h23;
      3: r[31:26] = 6'h2B;
      4: r[31:26] = 6'h04;
      5: r[31:26] = 6'h02;
      6: r[31:26] = bad[$urandom_range(0, 3)];
      default: begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
    endcase
    return r;
  endfunction

  initial begin
    int  len;
    bit  allow_ill;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    allow_ill = 1'b0;
`else
    allow_ill = 1'b1;
`endif
    // add $3,$1,$2 straight out of reset
    reset_and_load(32'h00221820, len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
    end
    check("retire_after_add", 64'(retire_cnt), 64'd1);
    issue(32'h8C080004);
    alu_zero = 1'b1;
    issue(32'h10000002);
    issue(32'h08000040);
    for (int n = 0; n < 150; n++) issue(rand_inst(allow_ill));
    check("retire_after_random", 64'(retire_cnt), 64'(m_ret));

    // Unsupported opcode 0x3F
    issue(32'hFC000000);
    check("illegal_set", 64'(illegal), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset asserted while lw sits in MEM
    reset_and_load(32'h8C080004, len);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_state_mem", 64'(state), 64'd3);
    rst = 1'b0;
    #1;
    check("mid_no_pc_en", 64'(pc_en), 64'd0);
    @(posedge clk);
    #1;
    check("mid_state_fetch", 64'(state), 64'd0);
    check("mid_retire_zero", 64'(retire_cnt), 64'd0);
    check("mid_pc_en_low", 64'(pc_en), 64'd0);
    @(posedge clk);
    #1;
    check("mid_illegal_zero", 64'(illegal), 64'd0);
    reset_and_load(32'h00221820, len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    check("final_retire", 64'(retire_cnt), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
